// File: rtl/line_align_ctrl_if.sv
// line_align_ctrl_if
// Groups every pixel-path and status signal of the line-alignment frame
// sequencer so the controller and its environment connect with one port.
//   slave  : the sequencer (line_align_ctrl) side
//   master : the environment side (pixel source + aligner + status sink)
// Signals:
//   src_data/src_valid/src_ready : pixel source handshake
//   la_data/la_valid             : pixel stream into the aligner
//   la_out_valid                 : aligned column valid from the aligner
//   win_*                        : position/marker tags for each aligned column
//   frame_done/busy/err          : frame status
interface line_align_ctrl_if #(
    parameter int DATA_WIDTH = 14,
    parameter int COL_W      = 7,
    parameter int ROW_W      = 7
);
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;
    logic                  src_ready;
    logic [DATA_WIDTH-1:0] la_data;
    logic                  la_valid;
    logic                  la_out_valid;
    logic                  win_valid;
    logic [COL_W-1:0]      win_col;
    logic [ROW_W-1:0]      win_row;
    logic                  win_sof;
    logic                  win_eol;
    logic                  win_eof;
    logic                  frame_done;
    logic                  busy;
    logic                  err;

    modport slave (
        input  src_data, src_valid, la_out_valid,
        output src_ready, la_data, la_valid,
        output win_valid, win_col, win_row, win_sof, win_eol, win_eof,
        output frame_done, busy, err
    );

    modport master (
        output src_data, src_valid, la_out_valid,
        input  src_ready, la_data, la_valid,
        input  win_valid, win_col, win_row, win_sof, win_eol, win_eof,
        input  frame_done, busy, err
    );
endinterface

// File: rtl/line_align_ctrl.sv
// line_align_ctrl
// Frame sequencer in front of the line-alignment buffer array. Forwards one
// IMAGE_WIDTH x IMAGE_HEIGHT frame from the source to the aligner with one
// cycle of latency, then injects (LINE_NUM-1) lines of PAD_VALUE so the
// aligner can drain its last rows, and tags every aligned output column with
// its column/row position and sof/eol/eof markers.
// Ports:
//   clk   : rising-edge clock
//   arstn : asynchronous active-low reset
//   bus   : line_align_ctrl_if.slave (source handshake, aligner stream,
//           aligner output valid, window tags, frame status)
module line_align_ctrl #(
    parameter int                    DATA_WIDTH   = 14,
    parameter int                    LINE_NUM     = 3,
    parameter int                    IMAGE_WIDTH  = 128,
    parameter int                    IMAGE_HEIGHT = 96,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
    input logic               clk,
    input logic               arstn,
    line_align_ctrl_if.slave  bus
);
    // Width needed to hold value N-1 is $clog2(N)
    localparam int CW   = $clog2(IMAGE_WIDTH);
    localparam int RW   = $clog2(IMAGE_HEIGHT);
    localparam int PADS = (LINE_NUM - 1) * IMAGE_WIDTH;
    localparam int PW   = $clog2(PADS);

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [PW-1:0] PAD_LAST = PW'(PADS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         in_col, in_col_nxt;
    logic [RW-1:0]         in_row, in_row_nxt;
    logic [PW-1:0]         pad_cnt, pad_cnt_nxt;
    logic                  pads_done, pads_done_nxt;
    logic [CW-1:0]         out_col, out_col_nxt;
    logic [RW-1:0]         out_row, out_row_nxt;
    logic [DATA_WIDTH-1:0] la_data_q, la_data_nxt;
    logic                  la_valid_q, la_valid_nxt;
    logic                  err_q, err_nxt;
    logic                  rdy_en;     // keeps src_ready low until the first edge after reset
    logic                  src_ready;
    logic                  accept;
    logic                  win_valid;

    // Ready is a function of registered state only, never of src_valid
    assign src_ready = rdy_en & ((state == IDLE) | (state == RUN));
    assign accept    = bus.src_valid & src_ready;
    assign win_valid = bus.la_out_valid & ((state == RUN) | (state == FLUSH));

    assign bus.src_ready  = src_ready;
    assign bus.la_data    = la_data_q;
    assign bus.la_valid   = la_valid_q;
    assign bus.win_valid  = win_valid;
    assign bus.win_col    = out_col;
    assign bus.win_row    = out_row;
    assign bus.win_sof    = win_valid & (out_col == '0) & (out_row == '0);
    assign bus.win_eol    = win_valid & (out_col == COL_LAST);
    assign bus.win_eof    = win_valid & (out_col == COL_LAST) & (out_row == ROW_LAST);
    assign bus.frame_done = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.err        = err_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= IDLE;
            in_col     <= '0;
            in_row     <= '0;
            pad_cnt    <= '0;
            pads_done  <= 1'b0;
            out_col    <= '0;
            out_row    <= '0;
            la_data_q  <= '0;
            la_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rdy_en     <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_col     <= in_col_nxt;
            in_row     <= in_row_nxt;
            pad_cnt    <= pad_cnt_nxt;
            pads_done  <= pads_done_nxt;
            out_col    <= out_col_nxt;
            out_row    <= out_row_nxt;
            la_data_q  <= la_data_nxt;
            la_valid_q <= la_valid_nxt;
            err_q      <= err_nxt;
            rdy_en     <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_col_nxt    = in_col;
        in_row_nxt    = in_row;
        pad_cnt_nxt   = pad_cnt;
        pads_done_nxt = pads_done;
        out_col_nxt   = out_col;
        out_row_nxt   = out_row;
        la_data_nxt   = la_data_q;
        la_valid_nxt  = 1'b0;
        // Aligner output with no frame in flight is a system fault; latch it
        err_nxt       = err_q | (bus.la_out_valid & (state == IDLE));

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = RUN;
                    in_col_nxt   = CW'(1);
                    la_valid_nxt = 1'b1;
                    la_data_nxt  = bus.src_data;
                end
            end
            RUN: begin
                if (accept) begin
                    la_valid_nxt = 1'b1;
                    la_data_nxt  = bus.src_data;
                    if (in_col == COL_LAST) begin
                        in_col_nxt = '0;
                        if (in_row == ROW_LAST) begin
                            in_row_nxt = '0;
                            state_nxt  = FLUSH;
                        end else begin
                            in_row_nxt = in_row + 1'b1;
                        end
                    end else begin
                        in_col_nxt = in_col + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Pads run at full rate independent of aligner output timing
                if (!pads_done) begin
                    la_valid_nxt = 1'b1;
                    la_data_nxt  = PAD_VALUE;
                    if (pad_cnt == PAD_LAST) begin
                        pad_cnt_nxt   = '0;
                        pads_done_nxt = 1'b1;
                    end else begin
                        pad_cnt_nxt = pad_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                in_col_nxt    = '0;
                in_row_nxt    = '0;
                pad_cnt_nxt   = '0;
                pads_done_nxt = 1'b0;
                out_col_nxt   = '0;
                out_row_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase

        // Output position counters advance on each tagged column; the last
        // column of the last row closes the frame once pads are flowing.
        if (win_valid) begin
            if (out_col == COL_LAST) begin
                out_col_nxt = '0;
                if (out_row == ROW_LAST) begin
                    out_row_nxt = '0;
                    if (state == FLUSH)
                        state_nxt = DONE;
                end else begin
                    out_row_nxt = out_row + 1'b1;
                end
            end else begin
                out_col_nxt = out_col + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_line_align_ctrl.sv
// Bench for line_align_ctrl at W=8, H=4, LINE_NUM=3. The environment models
// the aligner as "one output column per input pixel once (LINE_NUM-1) lines
// are buffered", delayed by a per-frame latency. A frame-level reference model
// derives the expected ready, stream contents, tags and status per cycle.
module tb_line_align_ctrl;
    localparam int DW   = 14;
    localparam int L    = 3;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);
    localparam int NPIX = W * H;
    localparam int NPAD = (L - 1) * W;
    localparam logic [DW-1:0] PAD = 14'h155;

    logic clk   = 1'b0;
    logic arstn = 1'b1;

    line_align_ctrl_if #(.DATA_WIDTH(DW), .COL_W(CW), .ROW_W(RW)) bus ();

    line_align_ctrl #(
        .DATA_WIDTH(DW), .LINE_NUM(L), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PAD_VALUE(PAD)
    ) dut (
        .clk(clk), .arstn(arstn), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int col;
        int row;
        int sof;
        int eol;
        int eof;
    } tag_vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit   started, blocked, fd_pend, rdy_ok, exp_err;
    int   acc, pads_left, win_cnt, lv_cnt, pv, dly, frames_done;
    bit   dl [4];
    logic [DW-1:0] exp_q [$];
    int   f_win, f_lv, f_pad, f_run, f_run_max;
    int   done_win, done_lv, done_pad, done_run;
    int   log_col [NPIX];
    int   log_row [NPIX];
    int   log_sof [NPIX];
    int   log_eol [NPIX];
    int   log_eof [NPIX];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        started = 0; blocked = 0; fd_pend = 0; rdy_ok = 0; exp_err = 0;
        acc = 0; pads_left = 0; win_cnt = 0; lv_cnt = 0;
        f_win = 0; f_lv = 0; f_pad = 0; f_run = 0; f_run_max = 0;
        exp_q.delete();
        foreach (dl[i]) dl[i] = 1'b0;
    endtask

    // Asserts reset immediately, holds it for n edges, releases at a negedge
    // and returns just after the first edge following release.
    task automatic do_reset(input int n);
        arstn = 1'b0;
        bus.src_valid = 1'b1;
        bus.la_out_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_src_ready", int'(bus.src_ready), 0);
        chk("rst_la_valid", int'(bus.la_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        repeat (n) begin
            @(posedge clk); #1;
            chk("rst_hold_src_ready", int'(bus.src_ready), 0);
            chk("rst_hold_la_valid", int'(bus.la_valid), 0);
            chk("rst_hold_busy", int'(bus.busy), 0);
        end
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk); #1;
        rdy_ok = 1;
        chk("rst_release_src_ready", int'(bus.src_ready), 1);
        bus.src_valid = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational/status outputs,
    // advance the model, then check the registered aligner stream.
    task automatic cyc(input bit sv, input bit force_lov);
        bit lov, fd_now, exp_rdy, exp_win, acc_now, exp_lv, newbit;
        int k;
        fd_now  = fd_pend;
        exp_rdy = rdy_ok && !blocked;
        lov     = force_lov || dl[dly-1];
        bus.src_valid    = sv;
        bus.src_data     = DW'(pv);
        bus.la_out_valid = lov;
        #1;
        chk("src_ready", int'(bus.src_ready), int'(exp_rdy));
        chk("busy", int'(bus.busy), int'(started));
        chk("frame_done", int'(bus.frame_done), int'(fd_now));
        chk("err", int'(bus.err), int'(exp_err));
        exp_win = lov && started && !fd_now;
        chk("win_valid", int'(bus.win_valid), int'(exp_win));
        if (exp_win && bus.win_valid && win_cnt < NPIX) begin
            k = win_cnt;
            chk("win_col", int'(bus.win_col), k % W);
            chk("win_row", int'(bus.win_row), k / W);
            chk("win_sof", int'(bus.win_sof), int'(k == 0));
            chk("win_eol", int'(bus.win_eol), int'((k % W) == W - 1));
            chk("win_eof", int'(bus.win_eof), int'(k == NPIX - 1));
            log_col[k] = int'(bus.win_col);
            log_row[k] = int'(bus.win_row);
            log_sof[k] = int'(bus.win_sof);
            log_eol[k] = int'(bus.win_eol);
            log_eof[k] = int'(bus.win_eof);
            win_cnt++;
            f_win++;
            if (win_cnt == NPIX) fd_pend = 1;
        end
        if (lov && !started) exp_err = 1;

        acc_now = sv && exp_rdy;
        exp_lv  = 0;
        if (acc_now) begin
            exp_lv = 1;
            exp_q.push_back(DW'(pv));
            pv++;
            acc++;
            started = 1;
            if (acc == NPIX) begin
                blocked   = 1;
                pads_left = NPAD;
                repeat (NPAD) exp_q.push_back(PAD);
            end
        end else if (pads_left > 0) begin
            exp_lv = 1;
            pads_left--;
        end
        if (fd_now) begin
            done_win = f_win; done_lv = f_lv; done_pad = f_pad; done_run = f_run_max;
            f_win = 0; f_lv = 0; f_pad = 0; f_run = 0; f_run_max = 0;
            fd_pend = 0; started = 0; blocked = 0;
            acc = 0; win_cnt = 0; lv_cnt = 0;
            frames_done++;
        end

        @(posedge clk); #1;
        rdy_ok = 1;
        chk("la_valid", int'(bus.la_valid), int'(exp_lv));
        if (bus.la_valid) begin
            f_lv++;
            f_run++;
            if (f_run > f_run_max) f_run_max = f_run;
            if (bus.la_data == PAD) f_pad++;
            if (exp_q.size() > 0) chk("la_data", int'(bus.la_data), int'(exp_q.pop_front()));
            else chk("la_data_extra", int'(bus.la_valid), 0);
        end else begin
            f_run = 0;
        end
        // aligner model: emits one column per pixel once L-1 lines are held
        newbit = bus.la_valid && (lv_cnt >= NPAD);
        if (bus.la_valid) lv_cnt++;
        dl[3] = dl[2]; dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = newbit;
    endtask

    // mode 0: back-to-back, 1: valid toggling 1,0, 2: valid held high, 3: random
    task automatic run_frame(input int mode);
        int start;
        int t;
        bit sv;
        start = frames_done;
        t = 0;
        while (frames_done == start && t < 600) begin
            case (mode)
                0: sv = !blocked;
                1: sv = ((t % 2) == 0) && !blocked;
                2: sv = 1'b1;
                default: sv = ($urandom_range(0, 3) != 0) && !blocked;
            endcase
            cyc(sv, 1'b0);
            t++;
        end
        chk("frame_completed", frames_done - start, 1);
    endtask

    task automatic frame_stats(input string tag, input bit b2b);
        chk({tag, "_win_count"}, done_win, NPIX);
        chk({tag, "_la_valid_count"}, done_lv, NPIX + NPAD);
        chk({tag, "_pad_count"}, done_pad, NPAD);
        if (b2b) chk({tag, "_la_valid_run"}, done_run, NPIX + NPAD);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tag_vec_t vec [6];
        int g;
        vec[0] = '{k: 0,  col: 0, row: 0, sof: 1, eol: 0, eof: 0};
        vec[1] = '{k: 7,  col: 7, row: 0, sof: 0, eol: 1, eof: 0};
        vec[2] = '{k: 8,  col: 0, row: 1, sof: 0, eol: 0, eof: 0};
        vec[3] = '{k: 15, col: 7, row: 1, sof: 0, eol: 1, eof: 0};
        vec[4] = '{k: 24, col: 0, row: 3, sof: 0, eol: 0, eof: 0};
        vec[5] = '{k: 31, col: 7, row: 3, sof: 0, eol: 1, eof: 1};

        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.la_out_valid = 1'b0;
        pv = 0; dly = 1; frames_done = 0;
        done_win = 0; done_lv = 0; done_pad = 0; done_run = 0;
        model_reset();
        #2;
        do_reset(3);

        // back-to-back frame, pixel value = index
        dly = 1;
        run_frame(0);
        frame_stats("b2b", 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("tbl_col", log_col[vec[i].k], vec[i].col);
            chk("tbl_row", log_row[vec[i].k], vec[i].row);
            chk("tbl_sof", log_sof[vec[i].k], vec[i].sof);
            chk("tbl_eol", log_eol[vec[i].k], vec[i].eol);
            chk("tbl_eof", log_eof[vec[i].k], vec[i].eof);
        end

        // source gaps
        dly = int'($urandom_range(1, 3));
        run_frame(1);
        frame_stats("gap", 1'b0);

        // src_valid held across the frame boundary into a second frame
        dly = 2;
        run_frame(2);
        frame_stats("held1", 1'b0);
        run_frame(2);
        frame_stats("held2", 1'b0);
        chk("held2_first_sof", log_sof[0], 1);
        chk("held2_first_col", log_col[0], 0);
        chk("held2_first_row", log_row[0], 0);

        // spurious aligner output in IDLE
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("err_sticky", int'(bus.err), 1);
        dly = int'($urandom_range(1, 3));
        run_frame(3);
        frame_stats("rand", 1'b0);
        chk("err_after_frame", int'(bus.err), 1);

        // reset mid-frame at in_row=2, in_col=5
        dly = 1;
        g = 0;
        while (acc < 2 * W + 5 && g < 100) begin
            cyc(1'b1, 1'b0);
            g++;
        end
        chk("midrst_accepts", acc, 2 * W + 5);
        do_reset(1);
        chk("midrst_err_cleared", int'(bus.err), 0);
        run_frame(0);
        frame_stats("post_rst", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_align_ctrl.md
# line_align_ctrl

Frame sequencer for the line-alignment buffer array. It sits between the pixel source and the aligner:
- accepts one frame of IMAGE_WIDTH×IMAGE_HEIGHT pixels through a valid/ready handshake and forwards them to the aligner;
- at end of frame, injects (LINE_NUM-1) lines of pad pixels so the aligner drains its last rows;
- tags every aligned output column with column/row position and frame markers.

## Interface
- DATA_WIDTH, 14, pixel width
- LINE_NUM, 3, lines held by the aligner (≥2)
- IMAGE_WIDTH, 128, pixels per line (≥2)
- IMAGE_HEIGHT, 96, lines per frame (≥2)
- PAD_VALUE, 0, pixel value injected during flush
- clk  in  1  single clock, rising edge
- arstn  in  1  asynchronous active-low reset
- src_data  in  DATA_WIDTH  source pixel
- src_valid  in  1  source pixel valid
- src_ready  out  1  controller accepts src_data this cycle
- la_data  out  DATA_WIDTH  pixel to aligner data_in (registered)
- la_valid  out  1  to aligner datain_valid (registered)
- la_out_valid  in  1  aligner dataout_valid
- win_valid  out  1  aligned column valid, equal to la_out_valid in RUN/FLUSH, 0 in IDLE
- win_col  out  clogb2(IMAGE_WIDTH-1)  column of current aligned output
- win_row  out  clogb2(IMAGE_HEIGHT-1)  row of current aligned output
- win_sof, win_eol, win_eof  out  1  qualified by win_valid: col=0&row=0; col=W-1; col=W-1&row=H-1
- frame_done  out  1  one-cycle pulse after last aligned output of frame
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: la_out_valid seen in IDLE; cleared only by reset

## Operation
- Counters:
  - in_col/in_row count accepted source pixels.
  - pad_cnt counts injected pads, 0 to (LINE_NUM-1)*IMAGE_WIDTH-1.
  - out_col/out_row count win_valid cycles.
  - All counters wrap at their bounds; no arithmetic beyond increment/compare.
- Accept: src_valid & src_ready. Each accepted pixel sets la_data=src_data, la_valid=1 on the next cycle.
- States:
  - IDLE: src_ready=1. First accept → RUN; in_col=1, counters otherwise 0.
  - RUN: src_ready=1. Accept of pixel (W-1,H-1) → FLUSH; in_col/in_row reset to 0.
  - FLUSH: src_ready=0. One pad per cycle (la_data=PAD_VALUE, la_valid=1) until pad_cnt reaches (LINE_NUM-1)*W, then la_valid=0. Leaves on the win_valid at out_col=W-1, out_row=H-1 → DONE.
  - DONE: one cycle, frame_done=1, src_ready=0 → IDLE with all counters 0.
- Output tagging:
  - win_col/win_row reflect counter values before increment on the win_valid cycle.
  - out_col wraps at W-1 and increments out_row.
- Pad injection continues regardless of win_valid timing. Exactly W*H win_valid cycles occur per frame.
- Source gaps (src_valid=0) in RUN: la_valid=0 that cycle, counters hold.
- la_out_valid in IDLE: win_valid=0, err set, counters unchanged.

## Timing
- Reset: src_ready=0 while arstn low, then 1 in IDLE. All other outputs are 0 and state is IDLE.
- Reset mid-frame: immediate asynchronous clear of all state; the partially written aligner is the system's responsibility to reset together.
- Source→aligner latency: 1 cycle. Pads start the cycle after the last source pixel appears on la_data, so the stream is back-to-back with no bubble if the source was back-to-back.
- win_* outputs are combinational from la_out_valid and registered counters, zero added latency.
- frame_done is asserted the cycle after the final win_valid.
- The earliest next-frame accept is the cycle after frame_done, when src_ready=1 again.
- src_ready never depends combinationally on src_valid.

## Test plan
Config for all scenarios: W=8, H=4, LINE_NUM=3.
- Reset: hold arstn low 3 cycles with src_valid=1 → src_ready=0, la_valid=0, busy=0. After release, src_ready=1 on the first clk edge.
- Back-to-back frame, pixel value = index 0..31:
  - la_valid high 48 consecutive cycles: 32 data then 16 PAD_VALUE.
  - exactly 32 win_valid cycles.
  - win_sof on the first, win_eol every 8th, win_eof on the 32nd.
  - frame_done 1 cycle later, busy low after it.
- Source gaps (src_valid toggling 1,0): la_valid mirrors accepts with 1-cycle delay. Pads still number 16, win count is 32, row/col tags identical to the back-to-back case.
- src_valid held high across the frame boundary: src_ready=0 from FLUSH through DONE, no pixel lost or duplicated. Second frame starts with win_row=0, win_col=0, win_sof=1.
- Spurious la_out_valid pulse in IDLE → win_valid=0, err=1 and stays 1 until arstn low.
- arstn low for 1 cycle at in_row=2, in_col=5 → all outputs cleared; next frame completes normally with 32 tagged outputs.
